// File: rtl/rc4_if.sv
// Handshake bundle for rc4_cipher_core: serial key load, text-in stream, text-out stream.
interface rc4_if #(parameter int WIDTH = 8);
    logic             start;
    logic             key_valid;
    logic [WIDTH-1:0] key_data;
    logic             key_ready;
    logic             busy;
    logic             data_rready;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             din_ready;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_ready;
    logic [WIDTH-1:0] num;

    modport master (
        output start, key_valid, key_data, din_valid, din, dout_ready,
        input  key_ready, busy, data_rready, din_ready, dout_valid, dout, num
    );
    modport slave (
        input  start, key_valid, key_data, din_valid, din, dout_ready,
        output key_ready, busy, data_rready, din_ready, dout_valid, dout, num
    );
endinterface

// File: rtl/rc4_cipher_core.sv
// RC4 engine: serial key load, INIT + KSA, then one keystream word per coded word.
// Define RC4_DROP_EN to discard DROP_N keystream words after the key schedule (RC4-drop[N]).
module rc4_cipher_core #(
    parameter int WIDTH   = 8,
    parameter int KEY_LEN = 16,
    parameter int DROP_N  = 768
) (
    input logic  clk,
    input logic  rst,
    rc4_if.slave bus
);
    localparam int N  = 2 ** WIDTH;
    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

    if (WIDTH < 4 || WIDTH > 8 || KEY_LEN < 1 || KEY_LEN > N || DROP_N < 0) begin : g_bad_param
        $error("rc4_cipher_core: illegal parameter set");
    end

`ifdef RC4_DROP_EN
    localparam int DW = $clog2(DROP_N + 2);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, KSA, DROP, CODE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, INIT, KSA, CODE} state_t;
`endif

    state_t                        state;
    logic [WIDTH-1:0]              i, j;
    logic [WIDTH-1:0]              ni, nj, si, sj, t, ks, ksa_j;
    logic [WIDTH-1:0]              s_mem [N];
    logic [KEY_LEN-1:0][WIDTH-1:0] key_mem;
    logic [KW-1:0]                 kidx;
    logic                          key_ready_q, busy_q, rready_q, dout_valid_q;
    logic [WIDTH-1:0]              dout_q, num_q;
    logic                          din_rdy, xfer, prga;
`ifdef RC4_DROP_EN
    logic [DW-1:0]                 dcnt;
`endif

    assign din_rdy = rready_q && (!dout_valid_q || bus.dout_ready);
    assign xfer    = bus.din_valid && din_rdy;
`ifdef RC4_DROP_EN
    assign prga    = xfer || (state == DROP);
`else
    assign prga    = xfer;
`endif
    assign ksa_j   = j + s_mem[i] + key_mem[kidx];

    // Keystream uses post-swap contents: S'[ni]=sj, S'[nj]=si.
    always_comb begin
        ni = i + WIDTH'(1);
        si = s_mem[ni];
        nj = j + si;
        sj = s_mem[nj];
        t  = si + sj;
        if (t == ni)      ks = sj;
        else if (t == nj) ks = si;
        else              ks = s_mem[t];
    end

    // State array is fully rewritten by INIT each session, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            s_mem[i] <= i;
        end else if (state == KSA) begin
            s_mem[i]     <= s_mem[ksa_j];
            s_mem[ksa_j] <= s_mem[i];
        end else if (prga) begin
            s_mem[ni] <= sj;
            s_mem[nj] <= si;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            i            <= '0;
            j            <= '0;
            kidx         <= '0;
            key_mem      <= '0;
            num_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            rready_q     <= 1'b0;
`ifdef RC4_DROP_EN
            dcnt         <= '0;
`endif
        end else if (bus.start) begin
            state        <= LOAD;
            i            <= '0;
            j            <= '0;
            kidx         <= '0;
            num_q        <= '0;
            dout_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b1;
            rready_q     <= 1'b0;
`ifdef RC4_DROP_EN
            dcnt         <= '0;
`endif
        end else begin
            case (state)
                LOAD: if (bus.key_valid) begin
                    key_mem[kidx] <= bus.key_data;
                    if (kidx == K_LAST) begin
                        kidx        <= '0;
                        i           <= '0;
                        key_ready_q <= 1'b0;
                        state       <= INIT;
                    end else begin
                        kidx <= kidx + KW'(1);
                    end
                end
                INIT: begin
                    i <= i + WIDTH'(1);
                    if (i == '1) begin
                        j     <= '0;
                        state <= KSA;
                    end
                end
                KSA: begin
                    i    <= i + WIDTH'(1);
                    j    <= ksa_j;
                    kidx <= (kidx == K_LAST) ? '0 : kidx + KW'(1);
                    if (i == '1) begin
                        j <= '0;
`ifdef RC4_DROP_EN
                        if (DROP_N > 0) begin
                            state <= DROP;
                        end else begin
                            state    <= CODE;
                            busy_q   <= 1'b0;
                            rready_q <= 1'b1;
                        end
`else
                        state    <= CODE;
                        busy_q   <= 1'b0;
                        rready_q <= 1'b1;
`endif
                    end
                end
`ifdef RC4_DROP_EN
                DROP: begin
                    i    <= ni;
                    j    <= nj;
                    dcnt <= dcnt + DW'(1);
                    if (dcnt == DW'(DROP_N - 1)) begin
                        state    <= CODE;
                        busy_q   <= 1'b0;
                        rready_q <= 1'b1;
                    end
                end
`endif
                CODE: begin
                    if (xfer) begin
                        i            <= ni;
                        j            <= nj;
                        dout_q       <= bus.din ^ ks;
                        dout_valid_q <= 1'b1;
                        num_q        <= num_q + WIDTH'(1);
                    end else if (bus.dout_ready) begin
                        dout_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.key_ready   = key_ready_q;
    assign bus.busy        = busy_q;
    assign bus.data_rready = rready_q;
    assign bus.din_ready   = din_rdy;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout        = dout_q;
    assign bus.num         = num_q;
endmodule

// File: tb/tb_rc4_cipher_core.sv
// Directed bench for rc4_cipher_core: array-based RC4 model checked every cycle plus literal vectors.
module tb_rc4_cipher_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef RC4_DROP_EN
    localparam int DROP = 4;
`else
    localparam int DROP = 0;
`endif

    logic       start, key_valid, din_valid, dout_ready;
    logic [7:0] key_data, din;
    int         sel;

    rc4_if #(.WIDTH(8)) b0();
    rc4_if #(.WIDTH(8)) b1();
    rc4_if #(.WIDTH(4)) b2();

    rc4_cipher_core #(.WIDTH(8), .KEY_LEN(3), .DROP_N(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    rc4_cipher_core #(.WIDTH(8), .KEY_LEN(4), .DROP_N(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    rc4_cipher_core #(.WIDTH(4), .KEY_LEN(1), .DROP_N(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.start = start && sel == 0;  assign b1.start = start && sel == 1;  assign b2.start = start && sel == 2;
    assign b0.key_valid = key_valid && sel == 0;
    assign b1.key_valid = key_valid && sel == 1;
    assign b2.key_valid = key_valid && sel == 2;
    assign b0.din_valid = din_valid && sel == 0;
    assign b1.din_valid = din_valid && sel == 1;
    assign b2.din_valid = din_valid && sel == 2;
    assign b0.dout_ready = (sel == 0) ? dout_ready : 1'b1;
    assign b1.dout_ready = (sel == 1) ? dout_ready : 1'b1;
    assign b2.dout_ready = (sel == 2) ? dout_ready : 1'b1;
    assign b0.key_data = key_data;       assign b1.key_data = key_data;  assign b2.key_data = key_data[3:0];
    assign b0.din = din;                 assign b1.din = din;            assign b2.din = din[3:0];

    logic       o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid;
    logic [7:0] o_dout, o_num;
    always_comb begin
        case (sel)
            0: {o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid, o_dout, o_num} =
               {b0.key_ready, b0.busy, b0.data_rready, b0.din_ready, b0.dout_valid, b0.dout, b0.num};
            1: {o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid, o_dout, o_num} =
               {b1.key_ready, b1.busy, b1.data_rready, b1.din_ready, b1.dout_valid, b1.dout, b1.num};
            default: {o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid, o_dout, o_num} =
               {b2.key_ready, b2.busy, b2.data_rready, b2.din_ready, b2.dout_valid, 4'h0, b2.dout, 4'h0, b2.num};
        endcase
    end

    int vecs = 0;
    int errs = 0;
    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference RC4 over plain int arrays
    int ms [256];
    int mkey [256];
    int mi, mj, mw, mnum;
    int exq [$];
    int got [$];
    bit mon_en = 1'b0;

    function automatic int model_ks();
        int n = 1 << mw;
        int tmp;
        mi = (mi + 1) % n;
        mj = (mj + ms[mi]) % n;
        tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
        return ms[(ms[mi] + ms[mj]) % n];
    endfunction

    task automatic model_init(input int w, input int klen);
        int n = 1 << w;
        int jj = 0;
        int tmp;
        for (int c = 0; c < n; c++) ms[c] = c;
        for (int c = 0; c < n; c++) begin
            jj = (jj + ms[c] + mkey[c % klen]) % n;
            tmp = ms[c]; ms[c] = ms[jj]; ms[jj] = tmp;
        end
        mi = 0; mj = 0; mw = w; mnum = 0;
        exq.delete();
        got.delete();
        for (int d = 0; d < DROP; d++) void'(model_ks());
    endtask

    // Per-cycle compare: dout against pending expectation, num against transfer count
    always @(negedge clk) begin
        if (mon_en && !rst && !start) begin
            if (o_dout_valid) begin
                if (exq.size() == 0) chk("dout_valid_unexpected", 1, 0);
                else begin
                    chk("dout_vs_model", o_dout, exq[0]);
                    if (dout_ready) begin
                        got.push_back(int'(o_dout));
                        void'(exq.pop_front());
                    end
                end
            end
            if (o_rready) chk("num_vs_model", o_num, mnum & ((1 << mw) - 1));
            if (din_valid && o_din_ready) begin
                exq.push_back((int'(din) ^ model_ks()) & ((1 << mw) - 1));
                mnum++;
            end
        end
    end

    task automatic pulse_start(input int s, input int klen, input int w);
        mon_en = 1'b0;
        sel = s;
        model_init(w, klen);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic load_key(input int klen);
        for (int k = 0; k < klen; k++) begin
            key_data = mkey[k][7:0];
            key_valid = 1'b1;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
    endtask

    task automatic drain();
        din_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic session(input int s, input int klen, input int w, input int exp_lat);
        int lat = 0;
        drain();
        pulse_start(s, klen, w);
        chk("key_ready_in_load", o_key_ready, 1);
        chk("busy_in_load", o_busy, 1);
        load_key(klen);
        chk("busy_after_key", o_busy, 1);
        while (!o_rready && lat < 3000) begin @(posedge clk); #1; lat++; end
        chk("rready_latency", lat, exp_lat);
        chk("busy_in_code", o_busy, 0);
    endtask

    task automatic send_din(input logic [7:0] v);
        int g = 0;
        din = v;
        din_valid = 1'b1;
        @(negedge clk);
        while (!o_din_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) chk("din_accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    logic [7:0] pt    [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] pt_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] pd    [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    logic [7:0] pd_ct [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] drop_ct [6] = '{8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    int ref1 [$];
    int ct [$];

    task automatic set_key_key();
        mkey[0] = 'h4B; mkey[1] = 'h65; mkey[2] = 'h79;
    endtask

    task automatic stall5();
        logic [7:0] held;
        dout_ready = 1'b0;
        @(negedge clk);
        held = o_dout;
        chk("stall_held_word", held, ref1[2]);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_dout_valid", o_dout_valid, 1);
            chk("stall_dout_stable", o_dout, held);
            chk("stall_din_ready", o_din_ready, 0);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; din_valid = 1'b0;
        dout_ready = 1'b1; key_data = '0; din = '0; sel = 0;
        #1;
        for (int s = 0; s < 3; s += 2) begin
            sel = s; #1;
            chk("reset_outputs", {o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid, o_dout, o_num}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Key/Plaintext, unstalled
        set_key_key();
        session(0, 3, 8, 512 + DROP);
        for (int b = 0; b < 9; b++) send_din(pt[b]);
        drain();
        chk("plaintext_count", got.size(), 9);
        chk("plaintext_num", o_num, 9);
`ifndef RC4_DROP_EN
        for (int b = 0; b < 9; b++) chk("plaintext_ct", got[b], int'(pt_ct[b]));
`endif
        ref1 = got;

        // Wiki/pedia, then decrypt back
        mkey[0] = 'h57; mkey[1] = 'h69; mkey[2] = 'h6B; mkey[3] = 'h69;
        session(1, 4, 8, 512 + DROP);
        for (int b = 0; b < 5; b++) send_din(pd[b]);
        drain();
`ifndef RC4_DROP_EN
        for (int b = 0; b < 5; b++) chk("pedia_ct", got[b], int'(pd_ct[b]));
`endif
        ct = got;
        session(1, 4, 8, 512 + DROP);
        for (int b = 0; b < 5; b++) send_din(ct[b][7:0]);
        drain();
        for (int b = 0; b < 5; b++) chk("pedia_roundtrip", got[b], int'(pd[b]));

        // Backpressure mid-stream
        set_key_key();
        session(0, 3, 8, 512 + DROP);
        for (int b = 0; b < 9; b++) begin
            if (b == 3) stall5();
            send_din(pt[b]);
        end
        drain();
        chk("stall_count", got.size(), 9);
        for (int b = 0; b < 9; b++) chk("stall_stream_eq", got[b], ref1[b]);

        // start mid-KSA, then full reload
        drain();
        pulse_start(0, 3, 8);
        load_key(3);
        repeat (300) @(posedge clk);
        #1;
        chk("busy_mid_ksa", o_busy, 1);
        session(0, 3, 8, 512 + DROP);
        for (int b = 0; b < 9; b++) send_din(pt[b]);
        drain();
        for (int b = 0; b < 9; b++) chk("restart_stream_eq", got[b], ref1[b]);

`ifdef RC4_DROP_EN
        session(0, 3, 8, 516);
        for (int b = 0; b < 6; b++) send_din(8'h00);
        drain();
        for (int b = 0; b < 6; b++) chk("drop4_ct", got[b], int'(drop_ct[b]));
`endif

        // rst asserted mid-CODE
        session(0, 3, 8, 512 + DROP);
        for (int b = 0; b < 3; b++) send_din(pt[b]);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {o_key_ready, o_busy, o_rready, o_din_ready, o_dout_valid, o_dout, o_num}, 0);
        din_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // WIDTH=4, KEY_LEN=1: 32-cycle schedule and num wrap
        mkey[0] = 'h5;
        session(2, 1, 4, 32 + DROP);
        for (int b = 0; b < 16; b++) send_din(8'(b * 3));
        drain();
        chk("w4_num_wrap", o_num, 0);
        send_din(8'h7);
        drain();
        chk("w4_num_after_wrap", o_num, 1);
        chk("w4_word_count", got.size(), 17);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
